// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared types and constants for the multiplier and its downstream accumulator
package multiplier_pkg;
  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;
  localparam int DEFAULT_WIDTH = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of up to MAX_TERMS products; ports: clk, rst, p_valid/p_ready/p_data/p_last in, acc_valid/acc_ready/acc_data/acc_count out
module product_accumulator
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PW = 2 * WIDTH,
  parameter int MAX_TERMS = 4,
  localparam int CNT_W = clog2(MAX_TERMS) + 1,
  localparam int ACC_W = PW + clog2(MAX_TERMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [PW-1:0]    p_data,
  input  logic             p_last,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic [CNT_W-1:0] acc_count
);
  state_t state, state_n;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic accept, closing;
  // sum and cnt are always zero in HOLD, so one close rule serves both states
  always_comb begin
    acc_valid = state == ST_HOLD;
    p_ready = acc_valid ? acc_ready : 1'b1;
    accept = p_valid && p_ready;
    closing = p_last || cnt == CNT_W'(MAX_TERMS - 1);
    state_n = accept && closing ? ST_HOLD : (acc_valid && acc_ready) ? ST_ACCUM : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
      sum <= '0;
      cnt <= '0;
      acc_data <= '0;
      acc_count <= '0;
    end else begin
      state <= state_n;
      if (accept && closing) begin
        acc_data <= sum + ACC_W'(p_data);
        acc_count <= cnt + CNT_W'(1);
        sum <= '0;
        cnt <= '0;
      end else if (accept) begin
        sum <= sum + ACC_W'(p_data);
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule
